// File: rtl/serie_paralelo_align.sv
// Serial-to-parallel receiver with COM symbol alignment and word lock.
// Optional macro LOSS_OF_LOCK_EN: drop lock after MAX_GAP consecutive words without an aligned COM.
module serie_paralelo_align #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_SYM    = WIDTH'(8'hBC),
    parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(8'h7C),
    parameter int               LOCK_COUNT = 4,
    parameter int               MAX_GAP    = 16
) (
    input  logic             clk32f,
    input  logic             reset,
    input  logic             in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_strobe,
    output logic             idle,
    output logic             valido,
    output logic             locked
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    if (WIDTH < 4 || LOCK_COUNT < 1 || MAX_GAP < 1) begin : g_param_check
        $error("serie_paralelo_align: WIDTH>=4, LOCK_COUNT>=1 and MAX_GAP>=1 required");
    end

    state_t           state;
    logic [WIDTH-2:0] sh;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    com_cnt;
    logic [WIDTH-1:0] window;
    logic             boundary;
    logic             is_com;
    logic             lose_lock;

    // The word ending on the bit being sampled this cycle.
    assign window   = {sh, in};
    assign boundary = (bit_cnt == BW'(WIDTH - 1));
    assign is_com   = (window == COM_SYM);

`ifdef LOSS_OF_LOCK_EN
    localparam int GW = $clog2(MAX_GAP + 1);

    logic [GW-1:0] gap_cnt;

    assign lose_lock = !is_com && (gap_cnt == GW'(MAX_GAP - 1));

    // Non-COM words seen at LOCKED boundaries since the last aligned COM.
    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state == LOCKED && boundary) begin
            gap_cnt <= (is_com || lose_lock) ? '0 : gap_cnt + 1'b1;
        end
    end
`else
    assign lose_lock = 1'b0;
`endif

    // NOTE: every register here uses <= so all of them see the pre-edge values of
    // state, bit_cnt and sh; blocking assignments would make the result order-dependent.
    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            sh          <= '0;
            bit_cnt     <= '0;
            com_cnt     <= '0;
            data_out    <= '0;
            data_strobe <= 1'b0;
            idle        <= 1'b0;
            valido      <= 1'b0;
            locked      <= 1'b0;
        end else begin
            sh          <= window[WIDTH-2:0];
            bit_cnt     <= boundary ? '0 : bit_cnt + 1'b1;
            // NOTE: the strobe defaults low here so it is a single-cycle pulse without
            // needing an explicit clear in every branch below.
            data_strobe <= 1'b0;

            case (state)
                SEARCH: begin
                    if (is_com) begin
                        bit_cnt <= '0;
                        com_cnt <= CW'(1);
                        if (LOCK_COUNT == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt <= com_cnt + 1'b1;
                            if (com_cnt == CW'(LOCK_COUNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            state   <= SEARCH;
                            com_cnt <= '0;
                        end
                    end
                end

                LOCKED: begin
                    if (boundary) begin
                        if (lose_lock) begin
                            // data_out keeps the last good word; no strobe for the dropped one.
                            state   <= SEARCH;
                            locked  <= 1'b0;
                            valido  <= 1'b0;
                            idle    <= 1'b0;
                            com_cnt <= '0;
                        end else begin
                            data_out    <= window;
                            data_strobe <= 1'b1;
                            idle        <= (window == IDLE_SYM);
                            valido      <= (window != COM_SYM) && (window != IDLE_SYM);
                        end
                    end
                end

                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serie_paralelo_align.sv
// Self-checking bench for serie_paralelo_align: WIDTH=8 and WIDTH=10 instances checked every cycle
// against a model that scans the recorded bit stream for COM alignment.
module tb_serie_paralelo_align;

    localparam logic [7:0] COM8   = 8'hBC;
    localparam logic [7:0] IDLE8  = 8'h7C;
    localparam logic [9:0] COM10  = 10'h17C;
    localparam logic [9:0] IDLE10 = 10'h283;
    localparam int LOCK8  = 4;
    localparam int GAP8   = 16;
    localparam int LOCK10 = 2;
    localparam int GAP10  = 5;
`ifdef LOSS_OF_LOCK_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk32f = 1'b0;
    logic       reset  = 1'b1;
    logic       in8    = 1'b0;
    logic       in10   = 1'b0;
    logic [7:0] data8;
    logic       strobe8, idle8, valido8, locked8;
    logic [9:0] data10;
    logic       strobe10, idle10, valido10, locked10;

    int checks = 0;
    int errors = 0;

    bit          stream[$];
    logic [15:0] e_data[$];
    bit          e_strobe[$];
    bit          e_idle[$];
    bit          e_valido[$];
    bit          e_locked[$];

    always #5 clk32f = ~clk32f;

    serie_paralelo_align #(
        .WIDTH(8), .COM_SYM(COM8), .IDLE_SYM(IDLE8), .LOCK_COUNT(LOCK8), .MAX_GAP(GAP8)
    ) dut8 (
        .clk32f(clk32f), .reset(reset), .in(in8), .data_out(data8), .data_strobe(strobe8),
        .idle(idle8), .valido(valido8), .locked(locked8)
    );

    serie_paralelo_align #(
        .WIDTH(10), .COM_SYM(COM10), .IDLE_SYM(IDLE10), .LOCK_COUNT(LOCK10), .MAX_GAP(GAP10)
    ) dut10 (
        .clk32f(clk32f), .reset(reset), .in(in10), .data_out(data10), .data_strobe(strobe10),
        .idle(idle10), .valido(valido10), .locked(locked10)
    );

    task automatic check(input string tag, input int t, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] v, input int w);
        for (int k = w - 1; k >= 0; k--) stream.push_back(v[k]);
    endtask

    task automatic push_bits(input int n);
        repeat (n) stream.push_back(1'($urandom_range(0, 1)));
    endtask

    // Last w stream bits ending at index t; bits before the reset release read as 0.
    function automatic logic [15:0] win_at(input int t, input int w);
        logic [15:0] v;
        v = '0;
        for (int k = t - w + 1; k <= t; k++) v = {v[14:0], (k >= 0) ? stream[k] : 1'b0};
        return v;
    endfunction

    // Scan the stream: find a COM, require lockc COMs spaced w bits apart, then every
    // w bits is an output word until (optionally) maxg non-COM words in a row.
    task automatic build_model(input int w, input logic [15:0] com, input logic [15:0] idl,
                               input int lockc, input int maxg);
        int          n, pos, t, b, cnt, gap;
        bit          failed, lost, s, id, va, lk;
        int          ev[$];
        logic [15:0] v, d;
        n = stream.size();
        for (int i = 0; i < n; i++) ev.push_back(0);
        pos = 0;
        while (pos < n) begin
            t = -1;
            for (int i = pos; i < n; i++) begin
                if (win_at(i, w) == com) begin
                    t = i;
                    break;
                end
            end
            if (t < 0) break;
            cnt = 1;
            b = t;
            failed = 0;
            while (cnt < lockc && !failed && b + w < n) begin
                b += w;
                if (win_at(b, w) == com) cnt++;
                else failed = 1;
            end
            if (failed) begin
                pos = b + 1;
                continue;
            end
            if (cnt < lockc) break;
            ev[b] = 3;
            gap = 0;
            lost = 0;
            b += w;
            while (b < n && !lost) begin
                v = win_at(b, w);
                if (LOSS_EN && v != com && gap + 1 == maxg) begin
                    ev[b] = 2;
                    lost = 1;
                end else begin
                    ev[b] = 1;
                    gap = (v == com) ? 0 : gap + 1;
                    b += w;
                end
            end
            if (!lost) break;
            pos = b + 1;
        end

        e_data.delete(); e_strobe.delete(); e_idle.delete(); e_valido.delete(); e_locked.delete();
        d = '0; id = 0; va = 0; lk = 0;
        for (int i = 0; i < n; i++) begin
            s = 0;
            case (ev[i])
                1: begin
                    d = win_at(i, w);
                    s = 1;
                    id = (d == idl);
                    va = (d != com) && (d != idl);
                end
                2: begin
                    lk = 0; id = 0; va = 0;
                end
                3: lk = 1;
                default: ;
            endcase
            e_data.push_back(d); e_strobe.push_back(s); e_idle.push_back(id);
            e_valido.push_back(va); e_locked.push_back(lk);
        end
    endtask

    task automatic check_all(input bit sel, input string name, input int t, input logic [15:0] d,
                             input bit s, input bit id, input bit va, input bit lk);
        logic [15:0] od;
        logic        os, oi, ov, ol;
        if (sel) begin
            od = 16'(data10); os = strobe10; oi = idle10; ov = valido10; ol = locked10;
        end else begin
            od = 16'(data8); os = strobe8; oi = idle8; ov = valido8; ol = locked8;
        end
        check({name, ".data_out"}, t, od, d);
        check({name, ".data_strobe"}, t, 16'(os), 16'(s));
        check({name, ".idle"}, t, 16'(oi), 16'(id));
        check({name, ".valido"}, t, 16'(ov), 16'(va));
        check({name, ".locked"}, t, 16'(ol), 16'(lk));
    endtask

    task automatic run_segment(input bit sel, input string name);
        if (sel) build_model(10, 16'(COM10), 16'(IDLE10), LOCK10, GAP10);
        else     build_model(8, 16'(COM8), 16'(IDLE8), LOCK8, GAP8);
        @(negedge clk32f);
        reset = 1'b1; in8 = 1'b0; in10 = 1'b0;
        @(negedge clk32f);
        reset = 1'b0;
        check_all(sel, {name, "/reset"}, -1, 16'h0, 0, 0, 0, 0);
        for (int t = 0; t < stream.size(); t++) begin
            if (sel) in10 = stream[t];
            else     in8 = stream[t];
            @(posedge clk32f);
            #1;
            check_all(sel, name, t, e_data[t], e_strobe[t], e_idle[t], e_valido[t], e_locked[t]);
            @(negedge clk32f);
        end
    endtask

    task automatic mid_reset(input bit sel, input string name);
        logic ol;
        ol = sel ? locked10 : locked8;
        check({name, ".locked_before"}, -1, 16'(ol), 16'h1);
        #2 reset = 1'b1;
        #1;
        check_all(sel, {name, "/async"}, -1, 16'h0, 0, 0, 0, 0);
        @(negedge clk32f);
        reset = 1'b0;
    endtask

    task automatic gen_random(input int w, input logic [15:0] com, input logic [15:0] idl,
                              input int lockc, input int nwords);
        stream.delete();
        push_bits($urandom_range(0, w - 1));
        repeat (lockc) push_word(com, w);
        repeat (nwords) begin
            case ($urandom_range(0, 9))
                0, 1, 2: push_word(com, w);
                3, 4:    push_word(idl, w);
                5:       push_bits($urandom_range(1, w - 1));
                default: push_word(16'($urandom), w);
            endcase
        end
    endtask

    initial begin
        // Lock after four aligned COMs, then data and idle words; reset lands mid-word.
        stream.delete();
        push_bits(3);
        repeat (4) push_word(16'(COM8), 8);
        push_word(16'h5A, 8);
        push_word(16'h7C, 8);
        repeat (3) push_word(16'($urandom), 8);
        push_bits(3);
        run_segment(0, "lock8");
        mid_reset(0, "midreset8");

        // A broken COM run sends the receiver back to searching.
        stream.delete();
        repeat (2) push_word(16'(COM8), 8);
        push_word(16'h00, 8);
        repeat (4) push_word(16'(COM8), 8);
        push_word(16'h5A, 8);
        push_word(16'h7C, 8);
        run_segment(0, "realign8");

        // A COM pattern straddling two data words must not move the boundary.
        stream.delete();
        repeat (4) push_word(16'(COM8), 8);
        push_word(16'h5A, 8);
        push_word(16'h0B, 8);
        push_word(16'hC0, 8);
        push_word(16'h0B, 8);
        push_word(16'hC0, 8);
        push_word(16'h7C, 8);
        push_word(16'h5A, 8);
        run_segment(0, "shifted8");

        // Sixteen words without COM after lock, then a fresh COM run.
        stream.delete();
        repeat (4) push_word(16'(COM8), 8);
        repeat (16) push_word(16'h11, 8);
        push_word(16'h5A, 8);
        repeat (4) push_word(16'(COM8), 8);
        push_word(16'h5A, 8);
        push_word(16'h7C, 8);
        run_segment(0, "gap8");

        // Ten-bit words.
        stream.delete();
        repeat (2) push_word(16'(COM10), 10);
        push_word(16'h155, 10);
        push_word(16'(IDLE10), 10);
        repeat (6) push_word(16'h0F0, 10);
        push_word(16'(COM10), 10);
        push_word(16'h2AA, 10);
        run_segment(1, "lock10");

        for (int i = 0; i < 3; i++) begin
            gen_random(8, 16'(COM8), 16'(IDLE8), LOCK8, 60);
            run_segment(0, "rand8");
        end
        for (int i = 0; i < 2; i++) begin
            gen_random(10, 16'(COM10), 16'(IDLE10), LOCK10, 50);
            run_segment(1, "rand10");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
